// File: rtl/riscv_pkg.sv
// Shared RISC-V datapath widths, ALU op codes and the ID/EX payload record.
package riscv_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned CTRL_W  = 7;
  localparam int unsigned RADDR_W = 5;

  // ALU op codes understood by main_ALU; NOP selects its default (zero) path.
  localparam logic [CTRL_W-1:0] ALU_NOP = 7'b0000000;
  localparam logic [CTRL_W-1:0] ALU_ADD = 7'b0011100;
  localparam logic [CTRL_W-1:0] ALU_SUB = 7'b0011101;
  localparam logic [CTRL_W-1:0] ALU_AND = 7'b0100101;

  // Everything the EX stage keeps about one instruction.
  typedef struct packed {
    logic                valid;
    logic [XLEN-1:0]     pc;
    logic [XLEN-1:0]     rs1_data;
    logic [XLEN-1:0]     rs2_data;
    logic [XLEN-1:0]     imm;
    logic [RADDR_W-1:0]  rs1_addr;
    logic [RADDR_W-1:0]  rs2_addr;
    logic [RADDR_W-1:0]  rd_addr;
    logic [CTRL_W-1:0]   alu_control;
    logic                src_imm;
    logic                src_pc;
    logic                reg_write;
  } ex_fields_t;

endpackage

// File: rtl/operand_fwd_mux.sv
// Resolves one source operand against in-flight MEM/WB results.
// Ports: rs_addr/reg_data  - source index and register-file value held in EX
//        mem_*/wb_*        - writer enable, destination and result of MEM and WB
//        fwd_data_c        - combinational forwarded operand
module operand_fwd_mux
  import riscv_pkg::*;
(
  input  logic [RADDR_W-1:0] rs_addr,
  input  logic [XLEN-1:0]    reg_data,
  input  logic               mem_we,
  input  logic [RADDR_W-1:0] mem_rd,
  input  logic [XLEN-1:0]    mem_data,
  input  logic               wb_we,
  input  logic [RADDR_W-1:0] wb_rd,
  input  logic [XLEN-1:0]    wb_data,
  output logic [XLEN-1:0]    fwd_data_c
);

  logic src_nonzero;
  logic mem_hit;
  logic wb_hit;

  // x0 is hard-wired zero, so it is never a forwarding target.
  assign src_nonzero = (rs_addr != RADDR_W'(0));
  assign mem_hit     = mem_we && (mem_rd == rs_addr) && src_nonzero;
  assign wb_hit      = wb_we  && (wb_rd  == rs_addr) && src_nonzero;

  // MEM holds the younger result, so it wins over WB.
  always_comb begin
    fwd_data_c = reg_data;
    if (mem_hit) begin
      fwd_data_c = mem_data;
    end else if (wb_hit) begin
      fwd_data_c = wb_data;
    end
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with operand forwarding feeding main_ALU.
// Ports: clk/reset (sync, active-high), stall/flush from the hazard unit,
//        id_*    - decoded fields of the instruction in ID
//        mem_fwd_*/wb_fwd_* - in-flight results for RAW bypass
//        A/B/ALU_control - ALU operands and op; ex_* - EX-stage bookkeeping
module id_ex_operand_stage
  import riscv_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               flush,
  input  logic               id_valid,
  input  logic [XLEN-1:0]    id_pc,
  input  logic [XLEN-1:0]    id_rs1_data,
  input  logic [XLEN-1:0]    id_rs2_data,
  input  logic [XLEN-1:0]    id_imm,
  input  logic [RADDR_W-1:0] id_rs1_addr,
  input  logic [RADDR_W-1:0] id_rs2_addr,
  input  logic [RADDR_W-1:0] id_rd_addr,
  input  logic [CTRL_W-1:0]  id_alu_control,
  input  logic               id_src_imm,
  input  logic               id_src_pc,
  input  logic               id_reg_write,
  input  logic               mem_fwd_we,
  input  logic [RADDR_W-1:0] mem_fwd_rd,
  input  logic [XLEN-1:0]    mem_fwd_data,
  input  logic               wb_fwd_we,
  input  logic [RADDR_W-1:0] wb_fwd_rd,
  input  logic [XLEN-1:0]    wb_fwd_data,
  output logic               ex_valid,
  output logic [XLEN-1:0]    A,
  output logic [XLEN-1:0]    B,
  output logic [CTRL_W-1:0]  ALU_control,
  output logic [XLEN-1:0]    ex_store_data,
  output logic [RADDR_W-1:0] ex_rd_addr,
  output logic               ex_reg_write,
  output logic [XLEN-1:0]    ex_pc
);

  ex_fields_t      ex_q;
  ex_fields_t      ex_d;
  logic [XLEN-1:0] fwd_rs1;
  logic [XLEN-1:0] fwd_rs2;

  operand_fwd_mux u_fwd_rs1 (
    .rs_addr    (ex_q.rs1_addr),
    .reg_data   (ex_q.rs1_data),
    .mem_we     (mem_fwd_we),
    .mem_rd     (mem_fwd_rd),
    .mem_data   (mem_fwd_data),
    .wb_we      (wb_fwd_we),
    .wb_rd      (wb_fwd_rd),
    .wb_data    (wb_fwd_data),
    .fwd_data_c (fwd_rs1)
  );

  operand_fwd_mux u_fwd_rs2 (
    .rs_addr    (ex_q.rs2_addr),
    .reg_data   (ex_q.rs2_data),
    .mem_we     (mem_fwd_we),
    .mem_rd     (mem_fwd_rd),
    .mem_data   (mem_fwd_data),
    .wb_we      (wb_fwd_we),
    .wb_rd      (wb_fwd_rd),
    .wb_data    (wb_fwd_data),
    .fwd_data_c (fwd_rs2)
  );

  // Next EX contents: flush > stall > advance (reset handled in the flop).
  always_comb begin
    ex_d = ex_q;
    if (flush) begin
      ex_d.valid       = 1'b0;
      ex_d.alu_control = ALU_NOP;
      ex_d.reg_write   = 1'b0;
    end else if (stall) begin
      // Re-capture forwarded operands so a producer retiring mid-stall is not lost.
      ex_d.rs1_data = fwd_rs1;
      ex_d.rs2_data = fwd_rs2;
    end else begin
      ex_d.valid       = id_valid;
      ex_d.pc          = id_pc;
      ex_d.rs1_data    = id_rs1_data;
      ex_d.rs2_data    = id_rs2_data;
      ex_d.imm         = id_imm;
      ex_d.rs1_addr    = id_rs1_addr;
      ex_d.rs2_addr    = id_rs2_addr;
      ex_d.rd_addr     = id_rd_addr;
      ex_d.alu_control = id_alu_control;
      ex_d.src_imm     = id_src_imm;
      ex_d.src_pc      = id_src_pc;
      ex_d.reg_write   = id_reg_write;
    end
  end

  // EX stage register.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  // Operand select and bubble gating toward main_ALU.
  assign ex_valid      = ex_q.valid;
  assign A             = ex_q.src_pc  ? ex_q.pc  : fwd_rs1;
  assign B             = ex_q.src_imm ? ex_q.imm : fwd_rs2;
  assign ex_store_data = fwd_rs2;
  assign ALU_control   = ex_q.valid ? ex_q.alu_control : ALU_NOP;
  assign ex_reg_write  = ex_q.valid & ex_q.reg_write;
  assign ex_rd_addr    = ex_q.rd_addr;
  assign ex_pc         = ex_q.pc;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Self-checking bench for id_ex_operand_stage: directed scenarios followed by
// randomized traffic, checked against an instruction-level model of the EX slot.
module tb_id_ex_operand_stage;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        reset, stall, flush, id_valid;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic [6:0]  id_alu_control;
  logic        id_src_imm, id_src_pc, id_reg_write;
  logic        mem_fwd_we, wb_fwd_we;
  logic [4:0]  mem_fwd_rd, wb_fwd_rd;
  logic [31:0] mem_fwd_data, wb_fwd_data;
  logic        ex_valid, ex_reg_write;
  logic [31:0] A, B, ex_store_data, ex_pc;
  logic [6:0]  ALU_control;
  logic [4:0]  ex_rd_addr;

  int checks = 0;
  int failures = 0;

  id_ex_operand_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_pc(id_pc), .id_rs1_data(id_rs1_data),
    .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_rs1_addr(id_rs1_addr),
    .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
    .id_alu_control(id_alu_control), .id_src_imm(id_src_imm),
    .id_src_pc(id_src_pc), .id_reg_write(id_reg_write),
    .mem_fwd_we(mem_fwd_we), .mem_fwd_rd(mem_fwd_rd), .mem_fwd_data(mem_fwd_data),
    .wb_fwd_we(wb_fwd_we), .wb_fwd_rd(wb_fwd_rd), .wb_fwd_data(wb_fwd_data),
    .ex_valid(ex_valid), .A(A), .B(B), .ALU_control(ALU_control),
    .ex_store_data(ex_store_data), .ex_rd_addr(ex_rd_addr),
    .ex_reg_write(ex_reg_write), .ex_pc(ex_pc)
  );

  always #5 clk = ~clk;

  // The instruction currently sitting in EX, as the model sees it.
  typedef struct {
    logic        valid;
    logic [31:0] pc, rs1v, rs2v, imm;
    logic [4:0]  rs1a, rs2a, rd;
    logic [6:0]  ctrl;
    logic        si, sp, rw;
  } instr_t;

  instr_t m;

  // Value an operand sees right now: youngest matching writer, x0 never bypassed.
  function automatic logic [31:0] operand(input logic [4:0] a, input logic [31:0] regv);
    if (a == 5'd0) return regv;
    if (mem_fwd_we && mem_fwd_rd == a) return mem_fwd_data;
    if (wb_fwd_we && wb_fwd_rd == a) return wb_fwd_data;
    return regv;
  endfunction

  function automatic instr_t successor(input instr_t cur);
    instr_t n;
    n = cur;
    if (reset) begin
      n.valid = 0; n.pc = 0; n.rs1v = 0; n.rs2v = 0; n.imm = 0;
      n.rs1a = 0; n.rs2a = 0; n.rd = 0; n.ctrl = 0; n.si = 0; n.sp = 0; n.rw = 0;
    end else if (flush) begin
      n.valid = 0; n.ctrl = 0; n.rw = 0;
    end else if (stall) begin
      n.rs1v = operand(cur.rs1a, cur.rs1v);
      n.rs2v = operand(cur.rs2a, cur.rs2v);
    end else begin
      n.valid = id_valid; n.pc = id_pc; n.rs1v = id_rs1_data; n.rs2v = id_rs2_data;
      n.imm = id_imm; n.rs1a = id_rs1_addr; n.rs2a = id_rs2_addr; n.rd = id_rd_addr;
      n.ctrl = id_alu_control; n.si = id_src_imm; n.sp = id_src_pc; n.rw = id_reg_write;
    end
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare every output against the model; payload only matters for real instructions.
  task automatic check_all(input string tag);
    chk({tag, ".ex_valid"}, 32'(ex_valid), 32'(m.valid));
    chk({tag, ".alu_ctrl"}, 32'(ALU_control), m.valid ? 32'(m.ctrl) : 32'd0);
    chk({tag, ".reg_write"}, 32'(ex_reg_write), 32'(m.valid & m.rw));
    if (m.valid) begin
      chk({tag, ".A"}, A, m.sp ? m.pc : operand(m.rs1a, m.rs1v));
      chk({tag, ".B"}, B, m.si ? m.imm : operand(m.rs2a, m.rs2v));
      chk({tag, ".store"}, ex_store_data, operand(m.rs2a, m.rs2v));
      chk({tag, ".pc"}, ex_pc, m.pc);
      chk({tag, ".rd"}, 32'(ex_rd_addr), 32'(m.rd));
    end
  endtask

  // One clock edge: model advances from the inputs present at the edge.
  task automatic tick();
    instr_t n;
    n = successor(m);
    @(posedge clk);
    m = n;
    #1;
  endtask

  task automatic no_fwd();
    mem_fwd_we = 0; mem_fwd_rd = 0; mem_fwd_data = 0;
    wb_fwd_we = 0; wb_fwd_rd = 0; wb_fwd_data = 0;
  endtask

  task automatic set_id(input logic v, input logic [4:0] r1, input logic [31:0] d1,
                        input logic [4:0] r2, input logic [31:0] d2, input logic [31:0] imm,
                        input logic si, input logic sp, input logic [6:0] ctrl);
    id_valid = v; id_rs1_addr = r1; id_rs1_data = d1; id_rs2_addr = r2; id_rs2_data = d2;
    id_imm = imm; id_src_imm = si; id_src_pc = sp; id_alu_control = ctrl;
    id_pc = $urandom; id_rd_addr = 5'($urandom); id_reg_write = 1'b1;
  endtask

  initial begin
    m = '{valid: 1'b1, pc: 32'hFFFF_FFFF, rs1v: 32'hFFFF_FFFF, rs2v: 32'hFFFF_FFFF,
          imm: 32'hFFFF_FFFF, rs1a: 5'h1F, rs2a: 5'h1F, rd: 5'h1F, ctrl: 7'h7F,
          si: 1'b1, sp: 1'b1, rw: 1'b1};
    stall = 0; flush = 0; no_fwd();

    // 1: reset two cycles while ID presents a valid instruction.
    reset = 1;
    set_id(1, 5'd1, 32'h1234, 5'd2, 32'h5678, 32'h9, 1, 0, ALU_ADD);
    tick(); tick();
    chk("rst.ex_valid", 32'(ex_valid), 32'd0);
    chk("rst.alu_ctrl", 32'(ALU_control), 32'd0);
    chk("rst.A", A, 32'd0);
    chk("rst.B", B, 32'd0);
    chk("rst.reg_write", 32'(ex_reg_write), 32'd0);
    check_all("rst");

    // 2: plain advance, one-cycle latency.
    reset = 0;
    set_id(1, 5'd1, 32'd5, 5'd2, 32'd9, 32'd7, 1, 0, ALU_ADD);
    tick();
    chk("adv.A", A, 32'd5);
    chk("adv.B", B, 32'd7);
    chk("adv.alu_ctrl", 32'(ALU_control), 32'h1C);
    check_all("adv");

    // 3: MEM and WB both write rs1 -> MEM wins.
    set_id(1, 5'd3, 32'h33, 5'd2, 32'h22, 32'd0, 0, 0, ALU_SUB);
    tick();
    mem_fwd_we = 1; mem_fwd_rd = 5'd3; mem_fwd_data = 32'hAA;
    wb_fwd_we = 1; wb_fwd_rd = 5'd3; wb_fwd_data = 32'hBB;
    #1;
    chk("prio.A", A, 32'hAA);
    check_all("prio");
    no_fwd();

    // 4: rs2 = x0 is never forwarded.
    set_id(1, 5'd1, 32'h1, 5'd0, 32'h0, 32'h0, 0, 0, ALU_AND);
    tick();
    mem_fwd_we = 1; mem_fwd_rd = 5'd0; mem_fwd_data = 32'h55;
    #1;
    chk("x0.B", B, 32'd0);
    chk("x0.store", ex_store_data, 32'd0);
    check_all("x0");
    no_fwd();

    // 5: stall across WB retirement keeps the forwarded value.
    set_id(1, 5'd4, 32'h99, 5'd5, 32'h77, 32'h0, 0, 0, ALU_ADD);
    tick();
    stall = 1;
    set_id(1, 5'd6, 32'hDEAD, 5'd7, 32'hBEEF, 32'h1, 1, 1, ALU_SUB);
    wb_fwd_we = 1; wb_fwd_rd = 5'd4; wb_fwd_data = 32'h11;
    #1;
    chk("stall0.A", A, 32'h11);
    tick();
    no_fwd();
    #1;
    chk("stall1.A", A, 32'h11);
    check_all("stall1");
    tick();
    chk("stall2.A", A, 32'h11);
    chk("stall2.alu_ctrl", 32'(ALU_control), 32'(ALU_ADD));
    check_all("stall2");

    // 6: flush with stall -> bubble.
    flush = 1;
    tick();
    chk("flush.ex_valid", 32'(ex_valid), 32'd0);
    chk("flush.alu_ctrl", 32'(ALU_control), 32'd0);
    chk("flush.reg_write", 32'(ex_reg_write), 32'd0);
    check_all("flush");
    flush = 0; stall = 0;

    // Randomized traffic with a narrow register range so hazards are frequent.
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 49) == 0);
      flush = ($urandom_range(0, 9) == 0);
      stall = ($urandom_range(0, 3) == 0);
      id_valid = 1'($urandom); id_pc = $urandom;
      id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
      id_rs1_addr = 5'($urandom_range(0, 3)); id_rs2_addr = 5'($urandom_range(0, 3));
      id_rd_addr = 5'($urandom); id_alu_control = 7'($urandom);
      id_src_imm = 1'($urandom); id_src_pc = 1'($urandom); id_reg_write = 1'($urandom);
      mem_fwd_we = 1'($urandom); mem_fwd_rd = 5'($urandom_range(0, 3)); mem_fwd_data = $urandom;
      wb_fwd_we = 1'($urandom); wb_fwd_rd = 5'($urandom_range(0, 3)); wb_fwd_data = $urandom;
      #1;
      check_all("rnd");
      tick();
    end
    #1;
    check_all("rnd_end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
